// File: rtl/dpram_be_if.sv
// Bus bundle for dpram_be: instruction fetch port plus read/write data port.
interface dpram_be_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned NB = DATA_WIDTH / 8;

    logic                  ce_i;
    logic [ADDR_WIDTH-1:0] pc_i;
    logic [DATA_WIDTH-1:0] inst_o;
    logic                  inst_valid_o;
    logic                  ram_ce_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  we_i;
    logic [NB-1:0]         sel_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  data_valid_o;
    logic                  misalign_o;

    modport master (
        output ce_i, pc_i, ram_ce_i, addr_i, data_i, we_i, sel_i,
        input  inst_o, inst_valid_o, data_o, data_valid_o, misalign_o
    );

    modport slave (
        input  ce_i, pc_i, ram_ce_i, addr_i, data_i, we_i, sel_i,
        output inst_o, inst_valid_o, data_o, data_valid_o, misalign_o
    );
endinterface

// File: rtl/dpram_be.sv
// Dual-port big-endian byte-lane RAM: read-only instruction port, read/write data port,
// 1- or 2-stage registered reads, configurable same-word collision behaviour.
module dpram_be #(
    parameter int unsigned RAM_SIZE       = 4096,
    parameter int unsigned RAM_ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned COLLISION_MODE = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    dpram_be_if.slave  bus
);
    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned WORDS = RAM_SIZE / NB;
    localparam int unsigned IDX_W = RAM_ADDR_WIDTH - OFF_W;

    if (!(READ_LATENCY == 1 || READ_LATENCY == 2)) begin : g_bad_latency
        $error("dpram_be: READ_LATENCY must be 1 or 2");
    end

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic [IDX_W-1:0]      pc_idx_c;
    logic [IDX_W-1:0]      addr_idx_c;
    logic                  wr_en_c;
    logic                  rd_en_c;
    logic [DATA_WIDTH-1:0] wmask_c;
    logic [DATA_WIDTH-1:0] data_old_c;
    logic [DATA_WIDTH-1:0] inst_rd_c;

    logic [DATA_WIDTH-1:0] inst_s1, data_s1;
    logic                  inst_v_s1, data_v_s1;
    logic                  misalign_q;

    assign pc_idx_c   = bus.pc_i[RAM_ADDR_WIDTH-1:OFF_W];
    assign addr_idx_c = bus.addr_i[RAM_ADDR_WIDTH-1:OFF_W];
    assign wr_en_c    = bus.ram_ce_i & bus.we_i & ~rst_i;
    assign rd_en_c    = bus.ram_ce_i & ~bus.we_i;

    // Lane mask from byte selects; collision merge only in write-first mode.
    always_comb begin
        wmask_c    = '0;
        data_old_c = mem[addr_idx_c];
        inst_rd_c  = mem[pc_idx_c];
        for (int k = 0; k < int'(NB); k++) begin
            wmask_c[8*k +: 8] = {8{bus.sel_i[k]}};
        end
        if (COLLISION_MODE == 1 && wr_en_c && pc_idx_c == addr_idx_c) begin
            inst_rd_c = (mem[pc_idx_c] & ~wmask_c) | (bus.data_i & wmask_c);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_c) begin
            mem[addr_idx_c] <= (data_old_c & ~wmask_c) | (bus.data_i & wmask_c);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inst_s1    <= '0;
            inst_v_s1  <= 1'b0;
            data_s1    <= '0;
            data_v_s1  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            inst_s1    <= bus.ce_i ? inst_rd_c : '0;
            inst_v_s1  <= bus.ce_i;
            data_s1    <= rd_en_c ? data_old_c : '0;
            data_v_s1  <= rd_en_c;
            misalign_q <= bus.ram_ce_i & (|bus.addr_i[OFF_W-1:0]);
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] inst_s2, data_s2;
        logic                  inst_v_s2, data_v_s2;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                inst_s2   <= '0;
                inst_v_s2 <= 1'b0;
                data_s2   <= '0;
                data_v_s2 <= 1'b0;
            end else begin
                inst_s2   <= inst_s1;
                inst_v_s2 <= inst_v_s1;
                data_s2   <= data_s1;
                data_v_s2 <= data_v_s1;
            end
        end

        assign bus.inst_o       = inst_s2;
        assign bus.inst_valid_o = inst_v_s2;
        assign bus.data_o       = data_s2;
        assign bus.data_valid_o = data_v_s2;
    end else begin : g_lat1
        assign bus.inst_o       = inst_s1;
        assign bus.inst_valid_o = inst_v_s1;
        assign bus.data_o       = data_s1;
        assign bus.data_valid_o = data_v_s1;
    end

    assign bus.misalign_o = misalign_q;

    // Backdoor byte access for debug; lane NB-1 holds the lowest byte address.
    function automatic logic [7:0] readByte(input logic [RAM_ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] w;
        w = mem[a[RAM_ADDR_WIDTH-1:OFF_W]];
        return w[8*(NB-1-32'(a[OFF_W-1:0])) +: 8];
    endfunction

    task automatic writeByte(input logic [RAM_ADDR_WIDTH-1:0] a, input logic [7:0] d);
        mem[a[RAM_ADDR_WIDTH-1:OFF_W]][8*(NB-1-32'(a[OFF_W-1:0])) +: 8] <= d;
    endtask
endmodule

// File: tb/tb_dpram_be.sv
// Scoreboard bench for dpram_be: two instances (latency 1/read-first, latency 2/write-first)
// share one directed stimulus stream; per-port monitors pop expected words on valid.
module tb_dpram_be;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        ce, ram_ce, we;
    logic [31:0] pc, addr, wdata;
    logic [3:0]  sel;

    dpram_be_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
    dpram_be_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

    assign ifa.ce_i = ce;  assign ifa.pc_i = pc;  assign ifa.ram_ce_i = ram_ce;
    assign ifa.addr_i = addr;  assign ifa.data_i = wdata;  assign ifa.we_i = we;  assign ifa.sel_i = sel;
    assign ifb.ce_i = ce;  assign ifb.pc_i = pc;  assign ifb.ram_ce_i = ram_ce;
    assign ifb.addr_i = addr;  assign ifb.data_i = wdata;  assign ifb.we_i = we;  assign ifb.sel_i = sel;

    dpram_be #(.RAM_SIZE(4096), .RAM_ADDR_WIDTH(12), .DATA_WIDTH(32),
               .READ_LATENCY(1), .COLLISION_MODE(0))
        dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa.slave));
    dpram_be #(.RAM_SIZE(4096), .RAM_ADDR_WIDTH(12), .DATA_WIDTH(32),
               .READ_LATENCY(2), .COLLISION_MODE(1))
        dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb.slave));

    int checks   = 0;
    int failures = 0;
    logic mon_en     = 1'b0;
    logic stream_win = 1'b0;
    int run_a = 0, run_b = 0, max_run_a = 0, max_run_b = 0;

    logic [31:0] q_inst_a[$], q_inst_b[$], q_data_a[$], q_data_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop on valid, require zero output when idle.
    always @(negedge clk) if (mon_en) begin
        if (ifa.inst_valid_o) begin
            if (q_inst_a.size() == 0) chk("inst_a_unexpected_valid", 32'(ifa.inst_valid_o), 0);
            else chk("inst_a", ifa.inst_o, q_inst_a.pop_front());
        end else chk("inst_a_idle_zero", ifa.inst_o, 0);
        if (ifb.inst_valid_o) begin
            if (q_inst_b.size() == 0) chk("inst_b_unexpected_valid", 32'(ifb.inst_valid_o), 0);
            else chk("inst_b", ifb.inst_o, q_inst_b.pop_front());
        end else chk("inst_b_idle_zero", ifb.inst_o, 0);
        if (ifa.data_valid_o) begin
            if (q_data_a.size() == 0) chk("data_a_unexpected_valid", 32'(ifa.data_valid_o), 0);
            else chk("data_a", ifa.data_o, q_data_a.pop_front());
        end else chk("data_a_idle_zero", ifa.data_o, 0);
        if (ifb.data_valid_o) begin
            if (q_data_b.size() == 0) chk("data_b_unexpected_valid", 32'(ifb.data_valid_o), 0);
            else chk("data_b", ifb.data_o, q_data_b.pop_front());
        end else chk("data_b_idle_zero", ifb.data_o, 0);
        if (stream_win) begin
            run_a = ifa.inst_valid_o ? run_a + 1 : 0;
            run_b = ifb.inst_valid_o ? run_b + 1 : 0;
            if (run_a > max_run_a) max_run_a = run_a;
            if (run_b > max_run_b) max_run_b = run_b;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ce = 1'b0; pc = '0; ram_ce = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        idle();
        ram_ce = 1'b1; we = 1'b1; addr = a; wdata = d; sel = s;
        tick();
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input bit push_b);
        idle();
        ram_ce = 1'b1; addr = a;
        q_data_a.push_back(exp);
        if (push_b) q_data_b.push_back(exp);
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_inst_a"}, ifa.inst_o, 0);        chk({tag, "_inst_b"}, ifb.inst_o, 0);
        chk({tag, "_data_a"}, ifa.data_o, 0);        chk({tag, "_data_b"}, ifb.data_o, 0);
        chk({tag, "_ivld_a"}, 32'(ifa.inst_valid_o), 0); chk({tag, "_ivld_b"}, 32'(ifb.inst_valid_o), 0);
        chk({tag, "_dvld_a"}, 32'(ifa.data_valid_o), 0); chk({tag, "_dvld_b"}, 32'(ifb.data_valid_o), 0);
        chk({tag, "_mis_a"}, 32'(ifa.misalign_o), 0);    chk({tag, "_mis_b"}, 32'(ifb.misalign_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk_reset_outputs("reset");
        mon_en = 1'b1;
        rst = 1'b0;
        tick();

        // Full-word write/read and latency of each instance
        wr(32'h010, 32'hDEADBEEF, 4'b1111);
        rd(32'h010, 32'hDEADBEEF, 1'b1);
        idle();
        @(negedge clk);
        chk("lat1_valid_a", 32'(ifa.data_valid_o), 1);
        chk("lat2_pending_b", 32'(ifb.data_valid_o), 0);
        tick();
        @(negedge clk);
        chk("lat2_valid_b", 32'(ifb.data_valid_o), 1);
        chk("lat1_single_valid_a", 32'(ifa.data_valid_o), 0);
        tick();

        // Byte lanes, big-endian: sel[3] is the lowest byte address
        wr(32'h020, 32'h11223344, 4'b1111);
        wr(32'h020, 32'hAABBCCDD, 4'b0101);
        rd(32'h020, 32'h11BB33DD, 1'b1);
        wr(32'h024, 32'h55667788, 4'b1111);
        wr(32'h024, 32'h00000000, 4'b0000);
        rd(32'h024, 32'h55667788, 1'b1);

        // Same-word collision: old word for read-first, merged lanes for write-first
        wr(32'h040, 32'h00000000, 4'b1111);
        idle();
        ram_ce = 1'b1; we = 1'b1; addr = 32'h040; wdata = 32'hFFFFFFFF; sel = 4'b1100;
        ce = 1'b1; pc = 32'h040;
        q_inst_a.push_back(32'h00000000);
        q_inst_b.push_back(32'hFFFF0000);
        tick();
        rd(32'h040, 32'hFFFF0000, 1'b1);

        // Wrap and misalignment
        wr(32'h1003, 32'h12345678, 4'b1111);
        idle();
        @(negedge clk);
        chk("misalign_set_a", 32'(ifa.misalign_o), 1);
        chk("misalign_set_b", 32'(ifb.misalign_o), 1);
        rd(32'h0000, 32'h12345678, 1'b1);
        idle();
        @(negedge clk);
        chk("misalign_clr_a", 32'(ifa.misalign_o), 0);
        chk("misalign_clr_b", 32'(ifb.misalign_o), 0);
        tick(); tick();

        // Reset right after a read: only the latency-1 instance has already presented it
        rd(32'h010, 32'hDEADBEEF, 1'b0);
        idle();
        rst = 1'b1;
        ram_ce = 1'b1; we = 1'b1; addr = 32'h010; wdata = 32'h0; sel = 4'b1111;
        tick();
        idle();
        tick();
        @(negedge clk);
        chk_reset_outputs("midreset");
        rst = 1'b0;
        tick(); tick();
        rd(32'h010, 32'hDEADBEEF, 1'b1);
        idle();
        tick(); tick();

        // Back-to-back instruction streaming
        for (int i = 0; i < 8; i++) wr(32'(4 * i), 32'hC0DE0000 + 32'(i), 4'b1111);
        idle();
        tick();
        stream_win = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idle();
            ce = 1'b1; pc = 32'(4 * i);
            q_inst_a.push_back(32'hC0DE0000 + 32'(i));
            q_inst_b.push_back(32'hC0DE0000 + 32'(i));
            tick();
        end
        idle();
        tick(); tick(); tick();
        stream_win = 1'b0;
        chk("stream_run_a", 32'(max_run_a), 8);
        chk("stream_run_b", 32'(max_run_b), 8);

        tick(); tick();
        chk("drain_inst_a", 32'(q_inst_a.size()), 0);
        chk("drain_inst_b", 32'(q_inst_b.size()), 0);
        chk("drain_data_a", 32'(q_data_a.size()), 0);
        chk("drain_data_b", 32'(q_data_b.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
